// File: rtl/cpu_pkg.sv
// Shared fetch-unit types: FSM state encoding, sticky fault codes, word shift.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    FAULT_NONE     = 2'b00,
    FAULT_MISALIGN = 2'b01,
    FAULT_RANGE    = 2'b10
  } fault_t;

  // Branch offsets and jump targets are in words; shift by this to get bytes.
  localparam int WORD_SHIFT = 2;

endpackage

// File: rtl/fetch_pc_unit_if.sv
// Decode-to-fetch control bundle plus the fetch unit's status outputs.
// Latency: n/a (wires only).
// Backpressure: stall is the only hold signal; it freezes the unit for one cycle.
interface fetch_pc_unit_if;

  logic        stall;
  logic        branch;
  logic        zero;
  logic [15:0] imm16;
  logic        jump;
  logic [25:0] target26;
  logic        jr;
  logic [31:0] jr_addr;

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        halted;
  logic [1:0]  fault;
  logic [31:0] fetch_count;

  // Decode side: drives control, observes fetch state.
  modport master (
    output stall, branch, zero, imm16, jump, target26, jr, jr_addr,
    input  pc, pc_plus4, halted, fault, fetch_count
  );

  // Fetch unit side.
  modport slave (
    input  stall, branch, zero, imm16, jump, target26, jr, jr_addr,
    output pc, pc_plus4, halted, fault, fetch_count
  );

endinterface

// File: rtl/next_pc_sel.sv
// Computes branch/jump targets and picks the next fetch address by priority.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the result is committed.
// FETCH_JR_EN: when defined, jr selects jr_addr above every other source.
module next_pc_sel
  import cpu_pkg::*;
(
  input  logic [31:0] pc_plus4,
  input  logic        branch,
  input  logic        zero,
  input  logic [15:0] imm16,
  input  logic        jump,
  input  logic [25:0] target26,
  input  logic        jr,
  input  logic [31:0] jr_addr,
  output logic [31:0] next_pc
);

  logic [31:0] imm_ext;
  logic [31:0] br_target;
  logic [31:0] j_target;

  assign imm_ext   = {{16{imm16[15]}}, imm16};
  // Sums wrap modulo 2^32; the carry out is intentionally dropped.
  assign br_target = pc_plus4 + (imm_ext << WORD_SHIFT);
  assign j_target  = {pc_plus4[31:28], target26, 2'b00};

`ifdef FETCH_JR_EN
  // Priority: jr > jump > taken branch > sequential.
  always_comb begin
    next_pc = pc_plus4;
    if (jr)                 next_pc = jr_addr;
    else if (jump)          next_pc = j_target;
    else if (branch && zero) next_pc = br_target;
  end
`else
  // jr path compiled out; its inputs are deliberately ignored.
  logic unused_jr_ok;
  assign unused_jr_ok = ^{jr, jr_addr};

  // Priority: jump > taken branch > sequential.
  always_comb begin
    next_pc = pc_plus4;
    if (jump)               next_pc = j_target;
    else if (branch && zero) next_pc = br_target;
  end
`endif

endmodule

// File: rtl/fetch_pc_unit.sv
// Program counter register with redirect, bounds/alignment fault and fetch counter.
// Latency: accepted redirect/advance appears on pc one cycle later.
// Backpressure: stall holds all state; a fault parks the unit in HALT until rst.
// FETCH_JR_EN: enables the jump-register redirect in next_pc_sel.
module fetch_pc_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_BYTES = 256
) (
  input logic             clk,
  input logic             rst,
  fetch_pc_unit_if.slave  bus
);

  localparam logic [31:0] PC_MAX = 32'(IMEM_BYTES - 4);

  state_t      state;
  fault_t      fault;
  logic [31:0] pc;
  logic [31:0] fetch_count;
  logic [31:0] pc_plus4;
  logic [31:0] next_pc;
  logic        misaligned;
  logic        out_of_range;

  assign pc_plus4 = pc + 32'd4;

  next_pc_sel u_sel (
    .pc_plus4 (pc_plus4),
    .branch   (bus.branch),
    .zero     (bus.zero),
    .imm16    (bus.imm16),
    .jump     (bus.jump),
    .target26 (bus.target26),
    .jr       (bus.jr),
    .jr_addr  (bus.jr_addr),
    .next_pc  (next_pc)
  );

  assign misaligned   = (next_pc[1:0] != 2'b00);
  assign out_of_range = (next_pc > PC_MAX);

  // RUN/HALT FSM owning pc, sticky fault and the fetch counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      fault       <= FAULT_NONE;
      fetch_count <= '0;
      state       <= RUN;
    end else begin
      case (state)
        RUN: begin
          if (!bus.stall) begin
            // Misalignment is reported in preference to range.
            if (misaligned) begin
              fault <= FAULT_MISALIGN;
              state <= HALT;
            end else if (out_of_range) begin
              fault <= FAULT_RANGE;
              state <= HALT;
            end else begin
              pc          <= next_pc;
              fetch_count <= fetch_count + 32'd1;
            end
          end
        end
        HALT: begin
          // Absorbing: only rst leaves this state.
        end
        default: state <= HALT;
      endcase
    end
  end

  assign bus.pc          = pc;
  assign bus.pc_plus4    = pc_plus4;
  assign bus.halted      = (state == HALT);
  assign bus.fault       = fault;
  assign bus.fetch_count = fetch_count;

endmodule

// File: doc/fetch_pc_unit.md
FETCH_PC_UNIT -- requirements
Module: fetch_pc_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, address loaded into pc on reset.
REQ-002 Parameter IMEM_BYTES, default 256, instruction memory size in bytes; legal pc range 0..IMEM_BYTES-4.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 stall  input  1  hold pc and counters this cycle.
REQ-006 branch  input  1  current instruction is beq.
REQ-007 zero  input  1  ALU zero flag for current instruction.
REQ-008 imm16  input  16  branch offset in words, signed.
REQ-009 jump  input  1  current instruction is j.
REQ-010 target26  input  26  jump word target.
REQ-011 jr  input  1  jump-register request (only used when FETCH_JR_EN is defined).
REQ-012 jr_addr  input  32  jump-register byte address.
REQ-013 pc  output  32  registered fetch address driven to instruction memory.
REQ-014 pc_plus4  output  32  pc + 4, combinational.
REQ-015 halted  output  1  unit is in HALT state.
REQ-016 fault  output  2  sticky fault code: 00 none, 01 misaligned, 10 out of range.
REQ-017 fetch_count  output  32  number of completed fetch advances since reset.

Function
REQ-018 States: RUN, HALT; reset enters RUN.
REQ-019 Next-pc priority: jr (if enabled) > jump > (branch & zero) > pc_plus4.
REQ-020 Branch target = pc_plus4 + (sign-extended imm16 << 2), modulo 2^32.
REQ-021 Jump target = {pc_plus4[31:28], target26, 2'b00}.
REQ-022 pc_plus4 and all target sums wrap modulo 2^32; no carry out.
REQ-023 In RUN with stall=0 and a legal next pc: pc <= next pc, fetch_count += 1 (wraps at 2^32), latency one cycle.
REQ-024 In RUN with stall=1: pc, fetch_count, state hold; control inputs ignored.
REQ-025 Next pc with [1:0] != 0 (stall=0): pc holds, fault <= 01, state <= HALT.
REQ-026 Next pc > IMEM_BYTES-4 and aligned (stall=0): pc holds, fault <= 10, state <= HALT.
REQ-027 Both misaligned and out of range: fault <= 01 (misaligned wins).
REQ-028 HALT is absorbing: pc, fault, fetch_count frozen; exit only by rst.
REQ-029 halted = 1 exactly when state is HALT.
REQ-030 branch=1 with zero=0 selects pc_plus4; jump and branch both high selects jump.

Reset
REQ-031 On rst=1 at a clock edge: pc <= RESET_PC, fault <= 00, fetch_count <= 0, state <= RUN.
REQ-032 rst overrides stall, HALT and every control input in the same cycle.
REQ-033 Reset mid-operation discards any pending redirect; first post-reset fetch is RESET_PC.

Configuration
REQ-034 Macro FETCH_JR_EN defined: jr selects jr_addr with highest priority, subject to REQ-025..027 checks.
REQ-035 FETCH_JR_EN undefined: jr and jr_addr are ignored; next-pc behaviour identical to REQ-019 minus jr.

Structure
REQ-036 Shared package cpu_pkg holds state encodings (RUN, HALT), fault codes, and the word-shift constant.
REQ-037 One combinational sub-module next_pc_sel computes targets and priority select; fetch_pc_unit owns all registers.

Verification
REQ-038 rst for 1 cycle, then 5 idle cycles -> pc 0,4,8,12,16,20; fetch_count 5.
REQ-039 pc=24, branch=1, zero=1, imm16=16'h0003 -> next pc 40; with zero=0 -> next pc 28.
REQ-040 pc=36, jump=1, target26=26'h6 -> next pc 24; branch=1,zero=1 same cycle -> still 24.
REQ-041 pc=252, no redirect -> pc stays 252, fault=10, halted=1; further cycles frozen; rst -> pc=0, fault=00.
REQ-042 FETCH_JR_EN defined, jr=1, jr_addr=32'h0000_0042 -> pc holds, fault=01, halted=1; undefined build -> pc advances to pc+4.
REQ-043 stall=1 for 3 cycles with jump=1 -> pc and fetch_count unchanged; stall released -> redirect taken next edge.
